// File: rtl/pu_demultiplexer.sv
`default_nettype none
// ============================================================================
//  Module   : pu_demultiplexer
//  Purpose  : Processing unit that routes one latched data word to one of
//             N = 2**SEL_WIDTH slots. After a value and a selector are loaded,
//             successive out_active cycles emit slots 0..N-1. The selected slot
//             carries the value and its attributes. Every other slot is zero.
//             A selector outside 0..N-1 turns every slot into an INVALID word.
//  Ports    : clk         - clock, rising edge
//             rst         - asynchronous reset, active-low
//             data_active - load value/attributes from data_in/attr_in
//             sel_active  - load selector from data_in
//                           (ignored while data_active is high)
//             out_active  - emit current slot (combinational), advance index
//             data_in     - signed bus data
//             attr_in     - bus attributes, bit 0 = INVALID
//             data_out    - slot value, 0 when out_active=0 or in reset
//             attr_out    - slot attributes, 0 when out_active=0 or in reset
//  Revision : 1.0 - initial release
// ============================================================================
module pu_demultiplexer #(
   parameter int DATA_WIDTH = 32,
   parameter int ATTR_WIDTH = 4,
   parameter int SEL_WIDTH  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  data_active,
   input  logic                  sel_active,
   input  logic                  out_active,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [ATTR_WIDTH-1:0] attr_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ATTR_WIDTH-1:0] attr_out
);

   // Derived operating state. No state register is kept for it; it is
   // decoded from the load flags and the slot index.
   localparam logic [1:0] ST_EMPTY    = 2'd0;
   localparam logic [1:0] ST_READY    = 2'd1;
   localparam logic [1:0] ST_EMITTING = 2'd2;

   localparam logic [SEL_WIDTH-1:0]  C_LAST_SLOT = {SEL_WIDTH{1'b1}};
   localparam logic [ATTR_WIDTH-1:0] C_INVALID   = ATTR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] value_reg_q,  value_reg_d;
   logic [ATTR_WIDTH-1:0] value_attr_q, value_attr_d;
   logic [SEL_WIDTH-1:0]  sel_reg_q,    sel_reg_d;
   logic                  sel_err_q,    sel_err_d;
   logic                  have_value_q, have_value_d;
   logic                  have_sel_q,   have_sel_d;
   logic [SEL_WIDTH-1:0]  slot_idx_q,   slot_idx_d;

   logic [1:0]            w_state;
   logic                  w_sel_hi;
   logic                  w_sel_bad;

   // A selector is out of range when it is negative or has any set bit above
   // the selector field. With a very wide selector only the sign bit matters.
   generate
      if (SEL_WIDTH < DATA_WIDTH - 1) begin : g_hi_chk
         assign w_sel_hi = |data_in[DATA_WIDTH-2:SEL_WIDTH];
      end else begin : g_no_hi_chk
         assign w_sel_hi = 1'b0;
      end
   endgenerate

   assign w_sel_bad = data_in[DATA_WIDTH-1] | w_sel_hi;

   always_comb begin
      w_state = ST_EMPTY;
      if (have_value_q && have_sel_q) begin
         w_state = (slot_idx_q == '0) ? ST_READY : ST_EMITTING;
      end
   end

   // Output slot. Driven purely from the pre-edge registers, so a load in
   // the same cycle as out_active does not disturb the slot being emitted.
   always_comb begin
      data_out = '0;
      attr_out = '0;
      if (rst && out_active) begin
         if (w_state == ST_EMPTY || sel_err_q) begin
            attr_out = C_INVALID;
         end else if (slot_idx_q == sel_reg_q) begin
            data_out = value_reg_q;
            attr_out = value_attr_q;
         end
      end
   end

   always_comb begin
      value_reg_d  = value_reg_q;
      value_attr_d = value_attr_q;
      sel_reg_d    = sel_reg_q;
      sel_err_d    = sel_err_q;
      have_value_d = have_value_q;
      have_sel_d   = have_sel_q;
      slot_idx_d   = slot_idx_q;

      if (data_active) begin
         // A value load restarts the sequence and overrides any slot
         // advance or wrap clear happening in the same cycle.
         value_reg_d  = data_in;
         value_attr_d = attr_in;
         have_value_d = 1'b1;
         slot_idx_d   = '0;
      end else if (sel_active) begin
         sel_reg_d    = data_in[SEL_WIDTH-1:0];
         sel_err_d    = w_sel_bad;
         have_sel_d   = 1'b1;
         slot_idx_d   = '0;
      end else if (out_active && w_state != ST_EMPTY) begin
         if (slot_idx_q == C_LAST_SLOT) begin
            slot_idx_d   = '0;
            have_value_d = 1'b0;
            have_sel_d   = 1'b0;
            sel_err_d    = 1'b0;
         end else begin
            slot_idx_d   = slot_idx_q + SEL_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         value_reg_q  <= '0;
         value_attr_q <= '0;
         sel_reg_q    <= '0;
         sel_err_q    <= 1'b0;
         have_value_q <= 1'b0;
         have_sel_q   <= 1'b0;
         slot_idx_q   <= '0;
      end else begin
         value_reg_q  <= value_reg_d;
         value_attr_q <= value_attr_d;
         sel_reg_q    <= sel_reg_d;
         sel_err_q    <= sel_err_d;
         have_value_q <= have_value_d;
         have_sel_q   <= have_sel_d;
         slot_idx_q   <= slot_idx_d;
      end
   end

endmodule
`default_nettype wire
